// File: rtl/wash_timer_pkg.sv
// Shared definitions for the wash phase timer: state encoding, default
// phase lengths, and the prescaler width helper.
package wash_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } phase_state_t;

  // Default phase lengths in seconds.
  localparam int FILL_SEC  = 120;
  localparam int WASH_SEC  = 300;
  localparam int RINSE_SEC = 120;
  localparam int SPIN_SEC  = 60;

  // Prescaler counter width: max(1, clog2(tps)).
  function automatic int presc_w(input int tps);
    return (tps <= 2) ? 1 : $clog2(tps);
  endfunction

endpackage

// File: rtl/wash_phase_timer_prescaler.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled and flags the
// wrap cycle with a combinational tick so the owner decrements on that edge.
module tick_prescaler
  import wash_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic clk,
  input  logic Counter_RST,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = presc_w(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] cnt;

  // With TICKS_PER_SEC=1 the counter sits at 0 == LAST, so every enabled cycle ticks.
  assign tick = enable && (cnt == LAST);

  // Clear wins over enable; the count holds whenever enable is low (pause).
  always_ff @(posedge clk or negedge Counter_RST) begin
    if (!Counter_RST)   cnt <= '0;
    else if (clear)     cnt <= '0;
    else if (enable)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Single-phase countdown timer for a washer: loads a duration in seconds,
// counts it down via the prescaler, supports pause (lid interlock) and abort,
// and pulses done once on completion. All outputs are registered.
module wash_phase_timer
  import wash_timer_pkg::*;
#(
  parameter int SEC_W         = 9,
  parameter int TICKS_PER_SEC = 4
) (
  input  logic             clk,
  input  logic             Counter_RST,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [SEC_W-1:0] duration,
  output logic [SEC_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  phase_state_t     st_q, st_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic start_ok, active, presc_en, presc_clr, tick;

  assign start_ok  = start && ((st_q == ST_IDLE) || (st_q == ST_DONE));
  assign active    = (st_q == ST_RUN) || (st_q == ST_PAUSE);
  // Leaving PAUSE counts on the same edge, so the held prescaler loses no cycle.
  assign presc_en  = active && !abort && !pause;
  assign presc_clr = abort || start_ok;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_presc (
    .clk        (clk),
    .Counter_RST(Counter_RST),
    .enable     (presc_en),
    .clear      (presc_clr),
    .tick       (tick)
  );

  // Next-state logic; priority abort > start > pause > tick.
  always_comb begin
    st_d   = st_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    if (abort) begin
      st_d  = ST_IDLE;
      rem_d = '0;
    end else if (start_ok) begin
      rem_d = duration;
      if (duration == '0) begin
        st_d   = ST_DONE;
        done_d = 1'b1;
      end else begin
        st_d = ST_RUN;
      end
    end else if (active) begin
      if (pause) begin
        st_d = ST_PAUSE;
      end else begin
        st_d = ST_RUN;
        if (tick && (rem_q != '0)) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == SEC_W'(1)) begin
            st_d   = ST_DONE;
            done_d = 1'b1;
          end
        end
      end
    end
    busy_d = (st_d == ST_RUN) || (st_d == ST_PAUSE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge Counter_RST) begin
    if (!Counter_RST) begin
      st_q   <= ST_IDLE;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign state     = st_q;
  assign remaining = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: one DUT at TICKS_PER_SEC=4, one at 1.
module tb_wash_phase_timer;

  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [SW-1:0] duration = '0;
  logic [SW-1:0] remaining;
  logic [1:0]    state;
  logic          busy, done;

  logic          start2 = 1'b0;
  logic [SW-1:0] duration2 = '0;
  logic [SW-1:0] remaining2;
  logic [1:0]    state2;
  logic          busy2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wash_phase_timer #(.SEC_W(SW), .TICKS_PER_SEC(4)) dut (
    .clk(clk), .Counter_RST(rst_n), .start(start), .pause(pause), .abort(abort),
    .duration(duration), .remaining(remaining), .state(state), .busy(busy), .done(done)
  );

  wash_phase_timer #(.SEC_W(SW), .TICKS_PER_SEC(1)) dut1 (
    .clk(clk), .Counter_RST(rst_n), .start(start2), .pause(1'b0), .abort(1'b0),
    .duration(duration2), .remaining(remaining2), .state(state2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for exactly one edge (that edge is "edge 0").
  task automatic do_start(input logic [SW-1:0] d);
    start = 1'b1; duration = d;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    bit saw_done;

    // Reset state
    #2;
    chk("rst_state", state, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Plain countdown, duration=3, TPS=4
    do_start(3);
    duration = 7;  // late change must not matter
    chk("t1_state0", state, 1);
    chk("t1_rem0", remaining, 3);
    chk("t1_busy0", busy, 1);
    step(3);  chk("t1_rem_e3", remaining, 3);
    step(1);  chk("t1_rem_e4", remaining, 2);
    step(4);  chk("t1_rem_e8", remaining, 1);
    step(3);  chk("t1_done_e11", done, 0);
    step(1);
    chk("t1_done_e12", done, 1);
    chk("t1_state_e12", state, 3);
    chk("t1_rem_e12", remaining, 0);
    chk("t1_busy_e12", busy, 0);
    step(1);
    chk("t1_done_e13", done, 0);
    chk("t1_state_e13", state, 3);
    chk("t1_rem_e13", remaining, 0);

    // Pause sampled on edges 6..10 delays completion by 5 cycles
    do_start(3);
    step(5);  chk("t2_rem_e5", remaining, 2);
    pause = 1'b1;
    step(1);
    chk("t2_state_e6", state, 2);
    chk("t2_busy_e6", busy, 1);
    chk("t2_rem_e6", remaining, 2);
    step(4);
    chk("t2_state_e10", state, 2);
    chk("t2_rem_e10", remaining, 2);
    pause = 1'b0;
    step(1);  chk("t2_state_e11", state, 1);
    step(2);  chk("t2_rem_e13", remaining, 1);
    step(3);  chk("t2_done_e16", done, 0);
    step(1);
    chk("t2_done_e17", done, 1);
    chk("t2_state_e17", state, 3);

    // Abort mid-phase, done never pulses
    do_start(5);
    step(6);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t3_state", state, 0);
    chk("t3_rem", remaining, 0);
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (done) saw_done = 1'b1;
    end
    chk("t3_no_done", saw_done, 0);
    chk("t3_state_late", state, 0);

    // Zero duration, pause ignored in DONE, restart from DONE
    do_start(0);
    chk("t4_state", state, 3);
    chk("t4_done", done, 1);
    chk("t4_rem", remaining, 0);
    step(1);  chk("t4_done_off", done, 0);
    pause = 1'b1;
    step(2);  chk("t4_pause_ign", state, 3);
    pause = 1'b0;
    do_start(2);
    chk("t4_run", state, 1);
    chk("t4_rem2", remaining, 2);
    step(7);  chk("t4_done_e7", done, 0);
    step(1);
    chk("t4_done_e8", done, 1);
    chk("t4_state_e8", state, 3);

    // Start ignored while running; abort beats start
    do_start(6);
    step(8);  chk("t5_rem_e8", remaining, 4);
    start = 1'b1; duration = 9;
    step(1);
    start = 1'b0;
    chk("t5_ign_rem", remaining, 4);
    chk("t5_ign_state", state, 1);
    step(3);  chk("t5_rem_e12", remaining, 3);
    abort = 1'b1; start = 1'b1; duration = 5;
    step(1);
    abort = 1'b0; start = 1'b0;
    chk("t5_ab_state", state, 0);
    chk("t5_ab_rem", remaining, 0);
    chk("t5_ab_busy", busy, 0);

    // Asynchronous reset mid-run
    do_start(3);
    step(4);  chk("t6_rem_e4", remaining, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", state, 0);
    chk("t6_rem", remaining, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    step(3);  chk("t6_done_hold", done, 0);
    rst_n = 1'b1;
    #2;
    do_start(1);
    chk("t6_restart", state, 1);
    chk("t6_restart_rem", remaining, 1);
    step(4);  chk("t6_done", done, 1);

    // TICKS_PER_SEC=1: one second per cycle
    start2 = 1'b1; duration2 = 300;
    step(1);
    start2 = 1'b0;
    chk("t7_rem0", remaining2, 300);
    step(299);
    chk("t7_rem_e299", remaining2, 1);
    chk("t7_done_e299", done2, 0);
    step(1);
    chk("t7_done_e300", done2, 1);
    chk("t7_state_e300", state2, 3);
    chk("t7_rem_e300", remaining2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
